// File: rtl/reg_file_dumper_pkg.sv
// Shared constants for the register-file dumper: register-file geometry,
// the all-zero data word and the dumper FSM state encodings.
package reg_file_dumper_pkg;

    // Register-file geometry
    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    // All-zero data word, used for buffer reset values
    localparam logic [REG_DATA_W-1:0] WORD_ZERO = '0;

    // Dumper FSM state encodings (3 bits)
    localparam logic [2:0] DMP_IDLE    = 3'd0;
    localparam logic [2:0] DMP_FETCH   = 3'd1;
    localparam logic [2:0] DMP_SEND_LO = 3'd2;
    localparam logic [2:0] DMP_SEND_HI = 3'd3;
    localparam logic [2:0] DMP_FIN     = 3'd4;

endpackage

// File: rtl/reg_file_dumper.sv
// Register-file dumper: on start, reads the register file two registers at
// a time (even index on port 1, odd index on port 2), buffers the pair and
// streams (index, value) words out over a valid/ready interface. freeze is
// held for the whole dump so the datapath can block register writes and the
// snapshot stays coherent. done pulses for one cycle after the last word.
module reg_file_dumper
    import reg_file_dumper_pkg::*;
#(
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int NUM_REG = REG_COUNT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] read_reg1,
    output logic [ADDR_W-1:0] read_reg2,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_index,
    output logic [DATA_W-1:0] dump_data,
    output logic              busy,
    output logic              freeze,
    output logic              done
);

    // One pair counter step covers an even/odd register pair
    localparam int PAIR_W = ADDR_W - 1;
    localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_REG / 2 - 1);

    logic [2:0]        state_reg, state_next;
    logic [PAIR_W-1:0] pair_reg, pair_next;
    logic [DATA_W-1:0] buf_lo_reg, buf_hi_reg;
    logic [ADDR_W-1:0] read_reg1_reg, read_reg2_reg;
    logic              enter_fetch;

    // Next-state and pair-counter logic; dump_ready only matters in the send states
    always_comb begin
        state_next = state_reg;
        pair_next  = pair_reg;
        case (state_reg)
            DMP_IDLE: begin
                if (start) begin
                    state_next = DMP_FETCH;
                    pair_next  = '0;
                end
            end
            DMP_FETCH: begin
                state_next = DMP_SEND_LO;
            end
            DMP_SEND_LO: begin
                if (dump_ready) begin
                    state_next = DMP_SEND_HI;
                end
            end
            DMP_SEND_HI: begin
                if (dump_ready) begin
                    if (pair_reg == LAST_PAIR) begin
                        state_next = DMP_FIN;
                    end else begin
                        state_next = DMP_FETCH;
                        pair_next  = pair_reg + 1'b1;
                    end
                end
            end
            DMP_FIN: begin
                state_next = DMP_IDLE;
            end
            default: begin
                state_next = DMP_IDLE;
            end
        endcase
    end

    // Read addresses are loaded on the way into FETCH so they are valid for
    // the whole FETCH cycle and simply hold afterwards
    assign enter_fetch = (state_next == DMP_FETCH) && (state_reg != DMP_FETCH);

    // FSM state and pair counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= DMP_IDLE;
            pair_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pair_reg  <= pair_next;
        end
    end

    // Register-file read addresses for the pair about to be fetched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_reg1_reg <= '0;
            read_reg2_reg <= '0;
        end else if (enter_fetch) begin
            read_reg1_reg <= {pair_next, 1'b0};
            read_reg2_reg <= {pair_next, 1'b1};
        end
    end

    // Capture both read ports on the FETCH edge; a write landing on the
    // same edge is not seen, so the snapshot holds pre-write contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_lo_reg <= DATA_W'(WORD_ZERO);
            buf_hi_reg <= DATA_W'(WORD_ZERO);
        end else if (state_reg == DMP_FETCH) begin
            buf_lo_reg <= read_data1;
            buf_hi_reg <= read_data2;
        end
    end

    // Outputs are decoded from registered state only, so there is no
    // combinational path from dump_ready to dump_valid
    assign read_reg1  = read_reg1_reg;
    assign read_reg2  = read_reg2_reg;
    assign dump_valid = (state_reg == DMP_SEND_LO) || (state_reg == DMP_SEND_HI);
    assign dump_index = (state_reg == DMP_SEND_HI) ? {pair_reg, 1'b1} : {pair_reg, 1'b0};
    assign dump_data  = (state_reg == DMP_SEND_HI) ? buf_hi_reg : buf_lo_reg;
    assign busy       = (state_reg != DMP_IDLE);
    assign freeze     = busy;
    assign done       = (state_reg == DMP_FIN);

endmodule

// File: tb/tb_reg_file_dumper.sv
// Self-checking bench for reg_file_dumper. A behavioural register file sits
// beside the DUT with its write port gated by freeze (optionally ungated).
// Expected dump streams are the register contents snapshotted by the bench
// at start, emitted as index 0..31 in order.
`timescale 1ns/1ps
module tb_reg_file_dumper;
    import reg_file_dumper_pkg::*;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int NUM_REG = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              dump_ready = 1'b0;
    logic [ADDR_W-1:0] read_reg1, read_reg2, dump_index;
    logic [DATA_W-1:0] read_data1, read_data2, dump_data;
    logic              dump_valid, busy, freeze, done;

    // Behavioural register file
    logic [DATA_W-1:0] rf [NUM_REG];
    logic              we = 1'b0;
    logic              wgate = 1'b1;
    logic [ADDR_W-1:0] waddr = '0;
    logic [DATA_W-1:0] wdata = '0;

    // Bench's own view of what the register file holds
    logic [DATA_W-1:0] snap [NUM_REG];

    int n_tests = 0;
    int n_fail  = 0;

    reg_file_dumper #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REG(NUM_REG)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_index (dump_index),
        .dump_data  (dump_data),
        .busy       (busy),
        .freeze     (freeze),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Register-file write port, gated by freeze when wgate is set
    always @(posedge clk) begin
        if (we && !(wgate && freeze)) rf[waddr] <= wdata;
    end

    assign read_data1 = rf[read_reg1];
    assign read_data2 = rf[read_reg2];

    // Stream monitor: records accepted words, done pulses and hold violations
    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
    } word_t;

    word_t stream[$];
    int    done_cnt = 0;
    int    hold_err = 0;
    logic  pend = 1'b0;
    word_t held;

    always @(posedge clk) begin
        if (!rst_n) begin
            pend <= 1'b0;
        end else begin
            if (pend && !(dump_valid && dump_index == held.idx && dump_data == held.data))
                hold_err <= hold_err + 1;
            if (dump_valid && dump_ready) stream.push_back({dump_index, dump_data});
            pend <= dump_valid && !dump_ready;
            held <= {dump_index, dump_data};
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic pick(input int pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    // Load every register through the write port (freeze is low in IDLE)
    task automatic preload(input int mult, input int add);
        for (int i = 0; i < NUM_REG; i++) begin
            @(negedge clk);
            we    = 1'b1;
            wgate = 1'b1;
            waddr = i[ADDR_W-1:0];
            wdata = DATA_W'(i * mult + add);
            snap[i] = DATA_W'(i * mult + add);
        end
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic single_write(input int addr, input logic [DATA_W-1:0] val);
        @(negedge clk);
        we    = 1'b1;
        wgate = 1'b1;
        waddr = addr[ADDR_W-1:0];
        wdata = val;
        snap[addr] = val;
        @(negedge clk);
        we = 1'b0;
    endtask

    // One full dump. restart_word: pulse start once when that many words
    // were accepted. gated_cyc: freeze-gated write of reg 5 on that cycle.
    // fetch_pair: ungated write to the even register on that pair's FETCH edge.
    task automatic run_dump(input string tag, input int pct, input int restart_word,
                            input int gated_cyc, input int fetch_pair, output int done_cyc);
        logic [DATA_W-1:0] exp_snap [NUM_REG];
        int  base_q;
        int  base_d;
        int  base_h;
        int  nwords;
        bit  restarted;
        exp_snap  = snap;
        base_q    = stream.size();
        base_d    = done_cnt;
        base_h    = hold_err;
        restarted = 1'b0;
        done_cyc  = -1;
        @(negedge clk);
        start      = 1'b1;
        dump_ready = pick(pct);
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            start = 1'b0;
            we    = 1'b0;
            if (k == 1) begin
                check({tag, "_fetch_busy"}, 64'(busy), 64'd1);
                check({tag, "_fetch_freeze"}, 64'(freeze), 64'd1);
                check({tag, "_fetch_novalid"}, 64'(dump_valid), 64'd0);
            end
            if (k == 2) begin
                check({tag, "_first_valid"}, 64'(dump_valid), 64'd1);
                check({tag, "_first_index"}, 64'(dump_index), 64'd0);
            end
            if (done) begin
                done_cyc = k;
                break;
            end
            dump_ready = pick(pct);
            if (restart_word >= 0 && !restarted && (stream.size() - base_q) == restart_word) begin
                start     = 1'b1;
                restarted = 1'b1;
            end
            if (k == gated_cyc) begin
                we    = 1'b1;
                wgate = 1'b1;
                waddr = 5'd5;
                wdata = 32'hFFFF_0000;
            end
            if (fetch_pair >= 0 && busy && !dump_valid && !done
                && int'(read_reg1) == 2 * fetch_pair) begin
                we    = 1'b1;
                wgate = 1'b0;
                waddr = read_reg1;
                wdata = 32'hDEAD_0000 | DATA_W'(k);
                snap[2 * fetch_pair] = 32'hDEAD_0000 | DATA_W'(k);
            end
        end
        we    = 1'b0;
        wgate = 1'b1;
        check({tag, "_done_seen"}, 64'(done_cyc > 0), 64'd1);
        @(negedge clk);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_done_count"}, 64'(done_cnt - base_d), 64'd1);
        check({tag, "_hold_ok"}, 64'(hold_err - base_h), 64'd0);
        nwords = stream.size() - base_q;
        check({tag, "_word_count"}, 64'(nwords), 64'(NUM_REG));
        for (int i = 0; i < NUM_REG && i < nwords; i++) begin
            check($sformatf("%s_idx%0d", tag, i), 64'(stream[base_q + i].idx), 64'(i));
            check($sformatf("%s_data%0d", tag, i), 64'(stream[base_q + i].data), 64'(exp_snap[i]));
        end
    endtask

    typedef struct {
        int mult;
        int add;
        int pct;
        int exp_cyc;
    } vec_t;

    initial begin
        vec_t vecs [4];
        int   dc;
        int   base;
        int   dc0;
        bit   found;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(dump_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_freeze", 64'(freeze), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_index", 64'(dump_index), 64'd0);
        check("rst_data", 64'(dump_data), 64'd0);
        check("rst_rr1", 64'(read_reg1), 64'd0);
        check("rst_rr2", 64'(read_reg2), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table of dumps: preload pattern, ready probability, expected done cycle
        vecs[0] = '{3, 0, 100, 49};
        vecs[1] = '{7, 5, 50, -1};
        vecs[2] = '{1, int'($urandom), 30, -1};
        vecs[3] = '{int'($urandom_range(1, 1000)), 32'h1000, 100, 49};
        for (int v = 0; v < 4; v++) begin
            preload(vecs[v].mult, vecs[v].add);
            run_dump($sformatf("vec%0d", v), vecs[v].pct, -1, -1, -1, dc);
            if (vecs[v].exp_cyc >= 0)
                check($sformatf("vec%0d_done_cycle", v), 64'(dc), 64'(vecs[v].exp_cyc));
        end

        // Freeze-gated write during a dump is dropped; a later write lands
        preload(3, 0);
        run_dump("gated", 100, -1, 5, -1, dc);
        single_write(5, 32'hFFFF_0000);
        run_dump("after_gate", 100, -1, -1, -1, dc);

        // start during a dump is ignored
        preload(11, 2);
        run_dump("restart", 50, 10, -1, -1, dc);

        // Ungated write to reg 2 on the FETCH edge of pair 1: old value dumped
        preload(3, 0);
        run_dump("fetchwr", 100, -1, -1, 1, dc);

        // Reset while SEND_HI of pair 7 is presented
        preload(5, 1);
        base = stream.size();
        @(negedge clk);
        start      = 1'b1;
        dump_ready = 1'b1;
        found      = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (dump_valid && dump_index == 5'd15) begin
                found = 1'b1;
                break;
            end
        end
        check("midrst_reached", 64'(found), 64'd1);
        dc0   = done_cnt;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(dump_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_freeze", 64'(freeze), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_partial_words", 64'(stream.size() - base), 64'd15);
        check("midrst_no_done", 64'(done_cnt - dc0), 64'd0);
        run_dump("post_rst", 100, -1, -1, -1, dc);
        check("post_rst_done_cycle", 64'(dc), 64'd49);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
